// File: rtl/axi_id_remap_stage.sv
// AXI4 ID compressor: maps wide crossbar IDs onto a small set of narrow ID slots.
// Zero-latency combinational forwarding; AW/AR stall while no slot is available.

package axi_id_remap_pkg;

    typedef struct packed {
        logic [5:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic        lock;
        logic [3:0]  cache;
        logic [2:0]  prot;
        logic [3:0]  qos;
        logic [5:0]  atop;
    } slv_aw_t;

    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic        lock;
        logic [3:0]  cache;
        logic [2:0]  prot;
        logic [3:0]  qos;
        logic [5:0]  atop;
    } mst_aw_t;

    typedef struct packed {
        logic [5:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic        lock;
        logic [3:0]  cache;
        logic [2:0]  prot;
        logic [3:0]  qos;
    } slv_ar_t;

    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic        lock;
        logic [3:0]  cache;
        logic [2:0]  prot;
        logic [3:0]  qos;
    } mst_ar_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
    } w_t;

    typedef struct packed {
        logic [5:0] id;
        logic [1:0] resp;
    } slv_b_t;

    typedef struct packed {
        logic [1:0] id;
        logic [1:0] resp;
    } mst_b_t;

    typedef struct packed {
        logic [5:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } slv_r_t;

    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } mst_r_t;

    typedef struct packed {
        slv_aw_t aw;
        logic    aw_valid;
        w_t      w;
        logic    w_valid;
        logic    b_ready;
        slv_ar_t ar;
        logic    ar_valid;
        logic    r_ready;
    } slv_req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        slv_b_t  b;
        logic    b_valid;
        slv_r_t  r;
        logic    r_valid;
    } slv_resp_t;

    typedef struct packed {
        mst_aw_t aw;
        logic    aw_valid;
        w_t      w;
        logic    w_valid;
        logic    b_ready;
        mst_ar_t ar;
        logic    ar_valid;
        logic    r_ready;
    } mst_req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        mst_b_t  b;
        logic    b_valid;
        mst_r_t  r;
        logic    r_valid;
    } mst_resp_t;

endpackage

// One direction's slot table plus the IDLE/HOLD FSM that pins the slot of a stalled request.
// Availability is purely registered state, so a freed slot becomes allocatable one cycle later.
module axi_id_remap_table #(
    parameter int unsigned SlvIdWidth   = 6,
    parameter int unsigned MaxUniqIds   = 4,
    parameter int unsigned MaxTxnsPerId = 8,
    localparam int unsigned IdxW = (MaxUniqIds > 1) ? $clog2(MaxUniqIds) : 1,
    localparam int unsigned CntW = $clog2(MaxTxnsPerId + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_vld,
    input  logic [SlvIdWidth-1:0] req_id,
    input  logic                  req_rdy,
    output logic                  avail,
    output logic [IdxW-1:0]       sel_idx,
    input  logic                  rsp_hs,
    input  logic                  rsp_dec,
    input  logic [IdxW-1:0]       rsp_idx,
    output logic [SlvIdWidth-1:0] rsp_slv_id
);

    typedef enum logic {IDLE, HOLD} state_e;

    state_e                state_q, state_d;
    logic [IdxW-1:0]       hold_idx_q, hold_idx_d;
    logic [MaxUniqIds-1:0] vld_q;
    logic [SlvIdWidth-1:0] sid_q [MaxUniqIds];
    logic [CntW-1:0]       cnt_q [MaxUniqIds];

    logic                  hit, any_free, alloc;
    logic [IdxW-1:0]       hit_idx, free_idx;
    logic [MaxUniqIds-1:0] inc_vec, dec_vec, pin_vec;

    // Descending scan so the lowest index wins for both the match and the free search.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        any_free = 1'b0;
        free_idx = '0;
        for (int i = MaxUniqIds - 1; i >= 0; i--) begin
            if (vld_q[i] && (sid_q[i] == req_id)) begin
                hit     = 1'b1;
                hit_idx = IdxW'(i);
            end
            if (!vld_q[i]) begin
                any_free = 1'b1;
                free_idx = IdxW'(i);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        hold_idx_d = hold_idx_q;
        avail      = 1'b0;
        sel_idx    = '0;
        case (state_q)
            IDLE: begin
                avail   = hit ? (cnt_q[hit_idx] != CntW'(MaxTxnsPerId)) : any_free;
                sel_idx = hit ? hit_idx : free_idx;
                if (req_vld && avail && !req_rdy) begin
                    state_d    = HOLD;
                    hold_idx_d = sel_idx;
                end
            end
            HOLD: begin
                avail   = 1'b1;
                sel_idx = hold_idx_q;
                if (req_vld && req_rdy) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    assign alloc      = req_vld && avail && req_rdy;
    assign rsp_slv_id = sid_q[rsp_idx];

    // A slot is pinned from the cycle it first stalls, so a same-cycle free cannot release it.
    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        pin_vec = '0;
        for (int i = 0; i < MaxUniqIds; i++) begin
            inc_vec[i] = alloc && (sel_idx == IdxW'(i));
            dec_vec[i] = rsp_dec && (rsp_idx == IdxW'(i));
            pin_vec[i] = (state_d == HOLD) && (hold_idx_d == IdxW'(i));
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            hold_idx_q <= '0;
            vld_q      <= '0;
            for (int i = 0; i < MaxUniqIds; i++) begin
                sid_q[i] <= '0;
                cnt_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            hold_idx_q <= hold_idx_d;
            for (int i = 0; i < MaxUniqIds; i++) begin
                if (inc_vec[i]) begin
                    vld_q[i] <= 1'b1;
                    sid_q[i] <= req_id;
                end else if (dec_vec[i] && (cnt_q[i] == CntW'(1)) && !pin_vec[i]) begin
                    vld_q[i] <= 1'b0;
                end
                if (inc_vec[i] && !dec_vec[i]) begin
                    cnt_q[i] <= cnt_q[i] + CntW'(1);
                end else if (!inc_vec[i] && dec_vec[i]) begin
                    cnt_q[i] <= cnt_q[i] - CntW'(1);
                end
            end
        end
    end

    assert property (@(posedge clk_i) disable iff (rst_i) rsp_hs |-> vld_q[rsp_idx]);
    assert property (@(posedge clk_i) disable iff (rst_i) rsp_dec |-> (cnt_q[rsp_idx] != '0));

endmodule

// Top: write and read tables around a straight AXI4 pass-through with ID rewriting.
// W passes untouched; every valid/ready toward either side is forced low during reset.
module axi_id_remap_stage #(
    parameter int unsigned SlvIdWidth   = 6,
    parameter int unsigned MstIdWidth   = 2,
    parameter int unsigned MaxUniqIds   = 4,
    parameter int unsigned MaxTxnsPerId = 8,
    parameter type slv_req_t  = axi_id_remap_pkg::slv_req_t,
    parameter type slv_resp_t = axi_id_remap_pkg::slv_resp_t,
    parameter type mst_req_t  = axi_id_remap_pkg::mst_req_t,
    parameter type mst_resp_t = axi_id_remap_pkg::mst_resp_t
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  slv_req_t  slv_req_i,
    output slv_resp_t slv_resp_o,
    output mst_req_t  mst_req_o,
    input  mst_resp_t mst_resp_i
);

    localparam int unsigned IdxW = (MaxUniqIds > 1) ? $clog2(MaxUniqIds) : 1;

    logic                  aw_req_vld, ar_req_vld, aw_avail, ar_avail;
    logic                  b_hs, r_hs, r_dec;
    logic [IdxW-1:0]       aw_idx, ar_idx;
    logic [SlvIdWidth-1:0] b_slv_id, r_slv_id;

    assign aw_req_vld = slv_req_i.aw_valid && !rst_i;
    assign ar_req_vld = slv_req_i.ar_valid && !rst_i;
    assign b_hs       = mst_resp_i.b_valid && slv_req_i.b_ready && !rst_i;
    assign r_hs       = mst_resp_i.r_valid && slv_req_i.r_ready && !rst_i;
    assign r_dec      = r_hs && mst_resp_i.r.last;

    axi_id_remap_table #(
        .SlvIdWidth   (SlvIdWidth),
        .MaxUniqIds   (MaxUniqIds),
        .MaxTxnsPerId (MaxTxnsPerId)
    ) i_wr_table (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .req_vld    (aw_req_vld),
        .req_id     (slv_req_i.aw.id),
        .req_rdy    (mst_resp_i.aw_ready),
        .avail      (aw_avail),
        .sel_idx    (aw_idx),
        .rsp_hs     (b_hs),
        .rsp_dec    (b_hs),
        .rsp_idx    (mst_resp_i.b.id[IdxW-1:0]),
        .rsp_slv_id (b_slv_id)
    );

    axi_id_remap_table #(
        .SlvIdWidth   (SlvIdWidth),
        .MaxUniqIds   (MaxUniqIds),
        .MaxTxnsPerId (MaxTxnsPerId)
    ) i_rd_table (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .req_vld    (ar_req_vld),
        .req_id     (slv_req_i.ar.id),
        .req_rdy    (mst_resp_i.ar_ready),
        .avail      (ar_avail),
        .sel_idx    (ar_idx),
        .rsp_hs     (r_hs),
        .rsp_dec    (r_dec),
        .rsp_idx    (mst_resp_i.r.id[IdxW-1:0]),
        .rsp_slv_id (r_slv_id)
    );

    always_comb begin
        mst_req_o  = '0;
        slv_resp_o = '0;

        mst_req_o.aw.id     = MstIdWidth'(aw_idx);
        mst_req_o.aw.addr   = slv_req_i.aw.addr;
        mst_req_o.aw.len    = slv_req_i.aw.len;
        mst_req_o.aw.size   = slv_req_i.aw.size;
        mst_req_o.aw.burst  = slv_req_i.aw.burst;
        mst_req_o.aw.lock   = slv_req_i.aw.lock;
        mst_req_o.aw.cache  = slv_req_i.aw.cache;
        mst_req_o.aw.prot   = slv_req_i.aw.prot;
        mst_req_o.aw.qos    = slv_req_i.aw.qos;
        mst_req_o.aw.atop   = slv_req_i.aw.atop;
        mst_req_o.aw_valid  = aw_req_vld && aw_avail;
        slv_resp_o.aw_ready = !rst_i && mst_resp_i.aw_ready && aw_avail;

        mst_req_o.ar.id     = MstIdWidth'(ar_idx);
        mst_req_o.ar.addr   = slv_req_i.ar.addr;
        mst_req_o.ar.len    = slv_req_i.ar.len;
        mst_req_o.ar.size   = slv_req_i.ar.size;
        mst_req_o.ar.burst  = slv_req_i.ar.burst;
        mst_req_o.ar.lock   = slv_req_i.ar.lock;
        mst_req_o.ar.cache  = slv_req_i.ar.cache;
        mst_req_o.ar.prot   = slv_req_i.ar.prot;
        mst_req_o.ar.qos    = slv_req_i.ar.qos;
        mst_req_o.ar_valid  = ar_req_vld && ar_avail;
        slv_resp_o.ar_ready = !rst_i && mst_resp_i.ar_ready && ar_avail;

        mst_req_o.w         = slv_req_i.w;
        mst_req_o.w_valid   = !rst_i && slv_req_i.w_valid;
        slv_resp_o.w_ready  = !rst_i && mst_resp_i.w_ready;

        slv_resp_o.b.id     = b_slv_id;
        slv_resp_o.b.resp   = mst_resp_i.b.resp;
        slv_resp_o.b_valid  = !rst_i && mst_resp_i.b_valid;
        mst_req_o.b_ready   = !rst_i && slv_req_i.b_ready;

        slv_resp_o.r.id     = r_slv_id;
        slv_resp_o.r.data   = mst_resp_i.r.data;
        slv_resp_o.r.resp   = mst_resp_i.r.resp;
        slv_resp_o.r.last   = mst_resp_i.r.last;
        slv_resp_o.r_valid  = !rst_i && mst_resp_i.r_valid;
        mst_req_o.r_ready   = !rst_i && slv_req_i.r_ready;
    end

    assert property (@(posedge clk_i) disable iff (rst_i) slv_req_i.aw_valid |-> (slv_req_i.aw.atop == '0));

endmodule

// File: tb/tb_axi_id_remap_stage.sv
// Directed bench for axi_id_remap_stage: drives just after the rising edge,
// checks combinational outputs on the falling edge against hand-computed values.
module tb_axi_id_remap_stage;
    import axi_id_remap_pkg::*;

    logic      clk = 1'b0;
    logic      rst;
    slv_req_t  slv_req;
    slv_resp_t slv_resp;
    mst_req_t  mst_req;
    mst_resp_t mst_resp;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    axi_id_remap_stage dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .slv_req_i  (slv_req),
        .slv_resp_o (slv_resp),
        .mst_req_o  (mst_req),
        .mst_resp_i (mst_resp)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        slv_req  = '0;
        mst_resp = '0;
    endtask

    task automatic drive_all_high();
        slv_req.aw_valid  = 1'b1;
        slv_req.w_valid   = 1'b1;
        slv_req.ar_valid  = 1'b1;
        slv_req.b_ready   = 1'b1;
        slv_req.r_ready   = 1'b1;
        mst_resp.aw_ready = 1'b1;
        mst_resp.w_ready  = 1'b1;
        mst_resp.ar_ready = 1'b1;
        mst_resp.b_valid  = 1'b1;
        mst_resp.r_valid  = 1'b1;
    endtask

    task automatic check_all_low(input string tag);
        chk(tag, {22'd0, mst_req.aw_valid, mst_req.w_valid, mst_req.ar_valid,
                  mst_req.b_ready, mst_req.r_ready, slv_resp.aw_ready, slv_resp.w_ready,
                  slv_resp.ar_ready, slv_resp.b_valid, slv_resp.r_valid}, 32'd0);
    endtask

    task automatic send_aw(input logic [5:0] id, input logic [1:0] slot, input string tag);
        slv_req.aw.id     = id;
        slv_req.aw.addr   = 32'h1000 + 32'(id);
        slv_req.aw.len    = 8'd3;
        slv_req.aw_valid  = 1'b1;
        mst_resp.aw_ready = 1'b1;
        @(negedge clk);
        chk({tag, ".vld"}, 32'(mst_req.aw_valid), 32'd1);
        chk({tag, ".id"}, 32'(mst_req.aw.id), 32'(slot));
        chk({tag, ".rdy"}, 32'(slv_resp.aw_ready), 32'd1);
        chk({tag, ".addr"}, mst_req.aw.addr, 32'h1000 + 32'(id));
        step();
        slv_req.aw_valid  = 1'b0;
        mst_resp.aw_ready = 1'b0;
    endtask

    task automatic send_ar(input logic [5:0] id, input logic [1:0] slot, input string tag);
        slv_req.ar.id     = id;
        slv_req.ar.addr   = 32'h2000 + 32'(id);
        slv_req.ar_valid  = 1'b1;
        mst_resp.ar_ready = 1'b1;
        @(negedge clk);
        chk({tag, ".vld"}, 32'(mst_req.ar_valid), 32'd1);
        chk({tag, ".id"}, 32'(mst_req.ar.id), 32'(slot));
        chk({tag, ".rdy"}, 32'(slv_resp.ar_ready), 32'd1);
        step();
        slv_req.ar_valid  = 1'b0;
        mst_resp.ar_ready = 1'b0;
    endtask

    task automatic send_b(input logic [1:0] mid, input logic [5:0] exp_sid, input string tag);
        mst_resp.b.id    = mid;
        mst_resp.b.resp  = 2'b10;
        mst_resp.b_valid = 1'b1;
        slv_req.b_ready  = 1'b1;
        @(negedge clk);
        chk({tag, ".bvld"}, 32'(slv_resp.b_valid), 32'd1);
        chk({tag, ".bid"}, 32'(slv_resp.b.id), 32'(exp_sid));
        chk({tag, ".bresp"}, 32'(slv_resp.b.resp), 32'd2);
        step();
        mst_resp.b_valid = 1'b0;
        slv_req.b_ready  = 1'b0;
    endtask

    task automatic send_r(input logic [1:0] mid, input logic last, input logic [5:0] exp_sid,
                          input string tag);
        mst_resp.r.id    = mid;
        mst_resp.r.data  = 32'hD000_0000 | 32'(exp_sid);
        mst_resp.r.last  = last;
        mst_resp.r_valid = 1'b1;
        slv_req.r_ready  = 1'b1;
        @(negedge clk);
        chk({tag, ".rid"}, 32'(slv_resp.r.id), 32'(exp_sid));
        chk({tag, ".rdat"}, slv_resp.r.data, 32'hD000_0000 | 32'(exp_sid));
        chk({tag, ".rlast"}, 32'(slv_resp.r.last), 32'(last));
        step();
        mst_resp.r_valid = 1'b0;
        slv_req.r_ready  = 1'b0;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        drive_all_high();
        @(negedge clk);
        check_all_low("rst0");
        step();
        step();
        idle_inputs();
        rst = 1'b0;
        step();

        // Single write: allocate slot 0, restore ID on B, slot reusable next cycle.
        send_aw(6'h2B, 2'd0, "s1.aw");
        send_b(2'd0, 6'h2B, "s1.b");
        send_aw(6'h15, 2'd0, "s1.reuse");
        send_b(2'd0, 6'h15, "s1.b2");

        // Fill all four slots, fifth ID stalls until a B frees slot 2.
        send_aw(6'h01, 2'd0, "s2.aw0");
        send_aw(6'h11, 2'd1, "s2.aw1");
        send_aw(6'h21, 2'd2, "s2.aw2");
        send_aw(6'h31, 2'd3, "s2.aw3");
        slv_req.aw.id     = 6'h05;
        slv_req.aw.addr   = 32'h1005;
        slv_req.aw_valid  = 1'b1;
        mst_resp.aw_ready = 1'b1;
        slv_req.w.data    = 32'hCAFE_0005;
        slv_req.w_valid   = 1'b1;
        mst_resp.w_ready  = 1'b1;
        @(negedge clk);
        chk("s2.stall_rdy", 32'(slv_resp.aw_ready), 32'd0);
        chk("s2.stall_vld", 32'(mst_req.aw_valid), 32'd0);
        chk("s2.w_vld", 32'(mst_req.w_valid), 32'd1);
        chk("s2.w_dat", mst_req.w.data, 32'hCAFE_0005);
        chk("s2.w_rdy", 32'(slv_resp.w_ready), 32'd1);
        step();
        slv_req.w_valid  = 1'b0;
        mst_resp.w_ready = 1'b0;
        mst_resp.b.id    = 2'd2;
        mst_resp.b_valid = 1'b1;
        slv_req.b_ready  = 1'b1;
        @(negedge clk);
        chk("s2.free_same_cyc", 32'(slv_resp.aw_ready), 32'd0);
        chk("s2.b_id", 32'(slv_resp.b.id), 32'h21);
        step();
        mst_resp.b_valid = 1'b0;
        slv_req.b_ready  = 1'b0;
        @(negedge clk);
        chk("s2.go_rdy", 32'(slv_resp.aw_ready), 32'd1);
        chk("s2.go_id", 32'(mst_req.aw.id), 32'd2);
        step();
        slv_req.aw_valid  = 1'b0;
        mst_resp.aw_ready = 1'b0;
        send_b(2'd0, 6'h01, "s2.d0");
        send_b(2'd1, 6'h11, "s2.d1");
        send_b(2'd3, 6'h31, "s2.d3");
        send_b(2'd2, 6'h05, "s2.d2");

        // Eight reads saturate slot 0; ninth waits for an R with last.
        for (int i = 0; i < 8; i++) send_ar(6'h07, 2'd0, "s3.ar");
        slv_req.ar.id     = 6'h07;
        slv_req.ar_valid  = 1'b1;
        mst_resp.ar_ready = 1'b1;
        @(negedge clk);
        chk("s3.full", 32'(slv_resp.ar_ready), 32'd0);
        step();
        mst_resp.r.id    = 2'd0;
        mst_resp.r.last  = 1'b0;
        mst_resp.r_valid = 1'b1;
        slv_req.r_ready  = 1'b1;
        @(negedge clk);
        chk("s3.r0_id", 32'(slv_resp.r.id), 32'h07);
        chk("s3.r0_rdy", 32'(slv_resp.ar_ready), 32'd0);
        step();
        mst_resp.r.last = 1'b1;
        @(negedge clk);
        chk("s3.r1_same_cyc", 32'(slv_resp.ar_ready), 32'd0);
        step();
        mst_resp.r_valid = 1'b0;
        slv_req.r_ready  = 1'b0;
        @(negedge clk);
        chk("s3.go_rdy", 32'(slv_resp.ar_ready), 32'd1);
        chk("s3.go_id", 32'(mst_req.ar.id), 32'd0);
        step();
        slv_req.ar_valid  = 1'b0;
        mst_resp.ar_ready = 1'b0;
        for (int i = 0; i < 8; i++) send_r(2'd0, 1'b1, 6'h07, "s3.drain");
        send_ar(6'h2C, 2'd0, "s3.empty");
        send_r(2'd0, 1'b1, 6'h2C, "s3.rlast");

        // Stalled AW keeps its ID while its slot drains to zero underneath it.
        send_aw(6'h10, 2'd0, "s4.a0");
        send_aw(6'h11, 2'd1, "s4.a1");
        send_aw(6'h2A, 2'd2, "s4.a2");
        send_b(2'd1, 6'h11, "s4.f1");
        slv_req.aw.id     = 6'h2A;
        slv_req.aw.addr   = 32'h102A;
        slv_req.aw_valid  = 1'b1;
        mst_resp.aw_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            mst_resp.b.id    = 2'd2;
            mst_resp.b_valid = (c == 1);
            slv_req.b_ready  = (c == 1);
            @(negedge clk);
            chk("s4.hold_id", 32'(mst_req.aw.id), 32'd2);
            step();
        end
        mst_resp.b_valid  = 1'b0;
        slv_req.b_ready   = 1'b0;
        mst_resp.aw_ready = 1'b1;
        @(negedge clk);
        chk("s4.hs_id", 32'(mst_req.aw.id), 32'd2);
        chk("s4.hs_rdy", 32'(slv_resp.aw_ready), 32'd1);
        step();
        slv_req.aw_valid  = 1'b0;
        mst_resp.aw_ready = 1'b0;
        send_b(2'd2, 6'h2A, "s4.after");
        send_b(2'd0, 6'h10, "s4.d0");

        // Allocate and free on slot 1 in the same cycle.
        send_aw(6'h20, 2'd0, "s5.a0");
        send_aw(6'h33, 2'd1, "s5.a1");
        send_aw(6'h33, 2'd1, "s5.a2");
        slv_req.aw.id     = 6'h33;
        slv_req.aw_valid  = 1'b1;
        mst_resp.aw_ready = 1'b1;
        mst_resp.b.id     = 2'd1;
        mst_resp.b_valid  = 1'b1;
        slv_req.b_ready   = 1'b1;
        @(negedge clk);
        chk("s5.aw_id", 32'(mst_req.aw.id), 32'd1);
        chk("s5.aw_rdy", 32'(slv_resp.aw_ready), 32'd1);
        chk("s5.b_id", 32'(slv_resp.b.id), 32'h33);
        step();
        idle_inputs();
        send_b(2'd1, 6'h33, "s5.d1a");
        send_b(2'd1, 6'h33, "s5.d1b");
        send_aw(6'h0E, 2'd1, "s5.reuse");
        send_b(2'd1, 6'h0E, "s5.d1c");
        send_b(2'd0, 6'h20, "s5.d0");

        // Reset with traffic outstanding discards both tables.
        send_aw(6'h01, 2'd0, "s6.w0");
        send_aw(6'h02, 2'd1, "s6.w1");
        send_aw(6'h03, 2'd2, "s6.w2");
        send_ar(6'h04, 2'd0, "s6.r0");
        send_ar(6'h05, 2'd1, "s6.r1");
        rst = 1'b1;
        drive_all_high();
        @(negedge clk);
        check_all_low("s6.rst_a");
        step();
        @(negedge clk);
        check_all_low("s6.rst_b");
        step();
        idle_inputs();
        rst = 1'b0;
        step();
        send_aw(6'h3F, 2'd0, "s6.aw");
        send_ar(6'h3E, 2'd0, "s6.ar");
        send_b(2'd0, 6'h3F, "s6.b");
        send_r(2'd0, 1'b1, 6'h3E, "s6.r");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
